// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller: FSM state encoding,
// LFSR/MISR widths, feedback taps, default seed and the LFSR step function.
package bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } bist_state_t;

    localparam int LFSR_W = 4;
    localparam int MISR_W = 5;

    // x^4+x^3+1: feedback is l[3]^l[2]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;
    // x^5+x^2+1: the bit shifted out of m[4] also folds into bit 2
    localparam logic [MISR_W-1:0] MISR_TAPS = 5'b00100;

    localparam logic [LFSR_W-1:0] DEF_SEED = 4'b0001;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 5-bit internal-XOR MISR (x^5+x^2+1) compacting CUT responses.
// Ports: clk, rst (async high), clr (sync clear), en (absorb din), din, sig.
module bist_misr
    import bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;
    logic [MISR_W-1:0] rot;

    // rotate gives n0=m4 and n(i)=m(i-1); taps add m4 into bit 2
    assign rot = {sig_q[MISR_W-2:0], sig_q[MISR_W-1]};

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = rot ^ (sig_q[MISR_W-1] ? MISR_TAPS : '0) ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_ctrl.sv
// BIST controller: LFSR pattern source, pattern counter and run FSM around a
// combinational CUT, with a MISR signature and pass/fail against GOLDEN.
// Ports: clk, rst (async high), start, busy, done, pass, signature,
//        cut_pi (pattern to CUT), cut_po (CUT response).
// Build option: define BIST_PIPE_EN to register cut_po before the MISR
// (adds a DRAIN cycle; final signature unchanged).
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int              PI_W    = 4,
    parameter int              PO_W    = 5,
    parameter int              PAT_CNT = 15,
    parameter logic [3:0]      SEED    = 4'b0001,
    parameter logic [4:0]      GOLDEN  = 5'b00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [PI_W-1:0]   cut_pi,
    input  logic [PO_W-1:0]   cut_po
);

    localparam logic [LFSR_W-1:0] SEED_N = (SEED == '0) ? DEF_SEED : SEED;
    localparam logic [3:0]        LAST   = 4'(PAT_CNT - 1);

    bist_state_t       state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              misr_clr;
    logic              misr_en;
    logic [PO_W-1:0]   misr_din;
    bist_state_t       run_exit;

`ifdef BIST_PIPE_EN
    logic [PO_W-1:0] po_q;
    logic            pvld_q;

    // pvld_q marks po_q as a real RUN response; the first RUN cycle is a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po_q   <= '0;
            pvld_q <= 1'b0;
        end else begin
            po_q   <= cut_po;
            pvld_q <= (state_q == S_RUN);
        end
    end

    assign misr_en  = pvld_q;
    assign misr_din = po_q;
    assign run_exit = S_DRAIN;
`else
    assign misr_en  = (state_q == S_RUN);
    assign misr_din = cut_po;
    assign run_exit = S_DONE;
`endif

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        misr_clr = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    lfsr_d   = SEED_N;
                    cnt_d    = '0;
                    misr_clr = 1'b1;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_next(lfsr_q);
                cnt_d  = 4'(cnt_q + 4'd1);
                if (cnt_q == LAST) begin
                    state_d = run_exit;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_N;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    bist_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din (misr_din),
        .sig (signature)
    );

    assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done   = (state_q == S_DONE);
    assign pass   = done && (signature == GOLDEN);
    assign cut_pi = (state_q == S_RUN) ? lfsr_q : SEED_N;

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: pattern order, MISR compaction against a
// GF(2) polynomial model, pass/fail, restart, and reset mid-run.
module tb_bist_ctrl;

`ifdef BIST_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_a = 0, start_b = 0, start_c = 0, start_d = 0;
    logic [4:0] po_a = 0, po_b = 0, po_c = 0, po_d = 0;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;
    logic       pass_a, pass_b, pass_c, pass_d;
    logic [4:0] sig_a, sig_b, sig_c, sig_d;
    logic [3:0] pi_a, pi_b, pi_c, pi_d;

    int checks = 0;
    int errors = 0;

    logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13,
                             4'd10, 4'd5, 4'd11, 4'd7, 4'd15, 4'd14,
                             4'd12, 4'd8};

    always #5 clk = ~clk;

    bist_ctrl #(.PAT_CNT(15), .SEED(4'b0001), .GOLDEN(5'b00000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .signature(sig_a),
        .cut_pi(pi_a), .cut_po(po_a));

    bist_ctrl #(.PAT_CNT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .signature(sig_b),
        .cut_pi(pi_b), .cut_po(po_b));

    bist_ctrl #(.PAT_CNT(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .signature(sig_c),
        .cut_pi(pi_c), .cut_po(po_c));

    bist_ctrl #(.PAT_CNT(15), .GOLDEN(5'b00001)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .busy(busy_d),
        .done(done_d), .pass(pass_d), .signature(sig_d),
        .cut_pi(pi_d), .cut_po(po_d));

    // signature polynomial times x, reduced mod x^5+x^2+1, plus response
    function automatic logic [4:0] mstep(input logic [4:0] s, input logic [4:0] po);
        logic [4:0] t;
        t = {s[3:0], 1'b0};
        if (s[4]) t = t ^ 5'b00101;
        return t ^ po;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // full run on dut_a; leaves it in DONE, start_a still high if hold
    task automatic run_a(input bit hold, input bit zero);
        logic [4:0] m;
        m = 5'b0;
        start_a = 1'b1;
        tick();
        if (!hold) start_a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (pi_a !== seq[k]) begin
                errors++;
                $display("FAIL pattern[%0d]: got %0d want %0d", k, pi_a, seq[k]);
            end
            checks++;
            if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL run_flags[%0d]: busy=%b done=%b want 1 0", k, busy_a, done_a);
            end
            po_a = zero ? 5'b0 : 5'($urandom);
            m = mstep(m, po_a);
            tick();
        end
        if (PIPE == 1) begin
            checks++;
            if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL drain_flags: busy=%b done=%b want 1 0", busy_a, done_a);
            end
            po_a = 5'($urandom);
            tick();
        end
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_latency: done=%b busy=%b want 1 0", done_a, busy_a);
        end
        checks++;
        if (sig_a !== m) begin
            errors++;
            $display("FAIL signature: got %b want %b", sig_a, m);
        end
        checks++;
        if (pass_a !== (m == 5'b0)) begin
            errors++;
            $display("FAIL pass_a: got %b want %b", pass_a, (m == 5'b0));
        end
        if (!hold) begin
            po_a = 5'($urandom);
            tick();
            checks++;
            if (sig_a !== m || done_a !== 1'b1) begin
                errors++;
                $display("FAIL hold_done: sig=%b done=%b want %b 1", sig_a, done_a, m);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({busy_a, done_a, pass_a, sig_a, pi_a} !== {3'b000, 5'b0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b sig=%b pi=%b",
                     busy_a, done_a, pass_a, sig_a, pi_a);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || pi_a !== 4'b0001) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b pi=%b want 0 0 0001",
                     busy_a, done_a, pi_a);
        end
    endtask

    task automatic test_sequence();
        run_a(1'b0, 1'b0);
        run_a(1'b0, 1'b0);
    endtask

    task automatic test_zero_pass();
        run_a(1'b0, 1'b1);
        checks++;
        if (pass_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_pass: got %b want 1", pass_a);
        end
    endtask

    task automatic test_single();
        po_b = 5'b10101;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (1 + PIPE) tick();
        checks++;
        if (done_b !== 1'b1 || sig_b !== 5'b10101) begin
            errors++;
            $display("FAIL misr_single: done=%b sig=%b want 1 10101", done_b, sig_b);
        end
    endtask

    task automatic test_two();
        po_c = 5'b00001;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        repeat (2 + PIPE) tick();
        checks++;
        if (done_c !== 1'b1 || sig_c !== 5'b00011) begin
            errors++;
            $display("FAIL misr_two: done=%b sig=%b want 1 00011", done_c, sig_c);
        end
    endtask

    task automatic test_fail();
        po_d = 5'b0;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        repeat (15 + PIPE) tick();
        checks++;
        if (done_d !== 1'b1 || pass_d !== 1'b0 || sig_d !== 5'b0) begin
            errors++;
            $display("FAIL golden_mismatch: done=%b pass=%b sig=%b want 1 0 00000",
                     done_d, pass_d, sig_d);
        end
    endtask

    task automatic test_restart();
        run_a(1'b1, 1'b0);
        tick();
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || sig_a !== 5'b0 || pi_a !== 4'b0001) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b sig=%b pi=%b want 1 0 00000 0001",
                     busy_a, done_a, sig_a, pi_a);
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        repeat (4) begin
            po_a = 5'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy_a, done_a, pass_a, sig_a, pi_a} !== {3'b000, 5'b0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b pass=%b sig=%b pi=%b",
                     busy_a, done_a, pass_a, sig_a, pi_a);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_zero_pass();
        test_single();
        test_two();
        test_fail();
        test_restart();
        test_reset_mid_run();
        run_a(1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
